// File: rtl/simple_fifo_512_reader_pkg.sv
// Shared widths, state codes and counter sizing for the simple_fifo_512 read/write adapters.
// The write-side packer imports the same defaults so both ends agree on word geometry.
package simple_fifo_512_reader_pkg;

    localparam int DEF_IN_WIDTH  = 512;
    localparam int DEF_OUT_WIDTH = 64;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND     = 2'd1;
    localparam logic [1:0] ST_SEND_BUF = 2'd2;

    function automatic int cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/simple_fifo_512_reader_word_slicer.sv
// Holds the word being sliced and emits it LSB slice first; a loaded word shows valid next cycle.
// Slice and last are held while advance is low; a final-beat advance can reload in the same cycle.
module word_slicer
    import simple_fifo_512_reader_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [IN_WIDTH-1:0]  load_data,
    input  logic                 advance,
    output logic [OUT_WIDTH-1:0] slice,
    output logic                 is_last,
    output logic                 valid
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = cnt_w(RATIO);

    logic [IN_WIDTH-1:0] cur;
    logic [CNT_W-1:0]    idx;

    assign is_last = valid && (idx == CNT_W'(RATIO - 1));

    always_comb begin
        slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == CNT_W'(i)) begin
                slice = cur[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur   <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (advance && valid) begin
            if (is_last) begin
                // Refill on the final beat keeps word boundaries bubble-free.
                idx   <= '0;
                valid <= load;
                if (load) begin
                    cur <= load_data;
                end
            end else begin
                idx <= idx + CNT_W'(1);
            end
        end else if (load && !valid) begin
            cur   <= load_data;
            idx   <= '0;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/simple_fifo_512_reader.sv
// Pops wide FIFO words and streams them as narrow beats; first beat two cycles after fifo_re.
// m_ready low stalls the current beat; at most two words are held and one read is outstanding.
module simple_fifo_512_reader
    import simple_fifo_512_reader_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fifo_re,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    input  logic                 fifo_empty,
    output logic                 m_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy
);

    logic                run;
    logic                rd_pend;
    logic                nxt_v;
    logic [IN_WIDTH-1:0] nxt;

    logic                cur_v;
    logic                is_last;
    logic                transfer;
    logic                done;
    logic                cur_free;
    logic                refill_from_nxt;
    logic                land_to_cur;
    logic                land_to_nxt;
    logic                rd_pend_into_nxt;
    logic                load;
    logic [IN_WIDTH-1:0] load_data;
    logic [1:0]          state;

    assign transfer         = cur_v && m_ready;
    assign done             = transfer && is_last;
    assign cur_free         = !cur_v || done;
    assign refill_from_nxt  = done && nxt_v;
    assign land_to_cur      = rd_pend && cur_free && !nxt_v;
    assign land_to_nxt      = rd_pend && !land_to_cur;
    assign rd_pend_into_nxt = rd_pend && !cur_free;
    assign load             = refill_from_nxt || land_to_cur;
    assign load_data        = refill_from_nxt ? nxt : fifo_dout;

    always_comb begin
        state = ST_IDLE;
        if (cur_v) begin
            state = nxt_v ? ST_SEND_BUF : ST_SEND;
        end
    end

    // run holds off popping for the first cycle after reset release.
    assign fifo_re = run && !fifo_empty && !rd_pend && (state != ST_SEND_BUF)
                     && !(cur_v && rd_pend_into_nxt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run     <= 1'b0;
            rd_pend <= 1'b0;
            nxt_v   <= 1'b0;
            nxt     <= '0;
        end else begin
            run     <= 1'b1;
            rd_pend <= fifo_re;
            if (land_to_nxt) begin
                nxt   <= fifo_dout;
                nxt_v <= 1'b1;
            end else if (refill_from_nxt) begin
                nxt_v <= 1'b0;
            end
        end
    end

    word_slicer #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_slicer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .advance   (transfer),
        .slice     (m_data),
        .is_last   (is_last),
        .valid     (cur_v)
    );

    assign m_valid = cur_v;
    assign m_last  = is_last;
    assign busy    = cur_v | nxt_v | rd_pend;

endmodule

// File: tb/tb_simple_fifo_512_reader.sv
// Directed bench: 512/64 instance against a 1-cycle-latency FIFO model, plus a 64/64 instance.
module tb_simple_fifo_512_reader;

    logic         clk;
    logic         reset;

    logic         fifo_re_a, fifo_empty_a, m_valid_a, m_last_a, m_ready_a, busy_a;
    logic [511:0] fifo_dout_a;
    logic [63:0]  m_data_a;

    logic         fifo_re_b, fifo_empty_b, m_valid_b, m_last_b, m_ready_b, busy_b;
    logic [63:0]  fifo_dout_b;
    logic [63:0]  m_data_b;

    int vecs = 0;
    int errs = 0;

    logic [511:0] mem_a [0:63];
    int           wp_a = 0;
    int           rp_a = 0;
    int           bad_pop_a = 0;
    logic [63:0]  mem_b [0:15];
    int           wp_b = 0;
    int           rp_b = 0;
    int           bad_pop_b = 0;

    logic [64:0]  exp_q [$];

    typedef struct {
        logic        push;
        logic        ready;
        logic        re;
        logic        vld;
        logic [63:0] dat;
        logic        last;
        logic        busy;
    } vec_t;
    vec_t tv [11];

    simple_fifo_512_reader #(.IN_WIDTH(512), .OUT_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .fifo_re(fifo_re_a), .fifo_dout(fifo_dout_a),
        .fifo_empty(fifo_empty_a), .m_valid(m_valid_a), .m_data(m_data_a),
        .m_last(m_last_a), .m_ready(m_ready_a), .busy(busy_a)
    );

    simple_fifo_512_reader #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut1 (
        .clk(clk), .reset(reset), .fifo_re(fifo_re_b), .fifo_dout(fifo_dout_b),
        .fifo_empty(fifo_empty_b), .m_valid(m_valid_b), .m_data(m_data_b),
        .m_last(m_last_b), .m_ready(m_ready_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_empty_a = (wp_a == rp_a);
    assign fifo_empty_b = (wp_b == rp_b);

    always @(posedge clk) begin
        if (fifo_re_a) begin
            if (wp_a != rp_a) begin
                fifo_dout_a <= mem_a[rp_a % 64];
                rp_a        <= rp_a + 1;
            end else begin
                bad_pop_a <= bad_pop_a + 1;
            end
        end
        if (fifo_re_b) begin
            if (wp_b != rp_b) begin
                fifo_dout_b <= mem_b[rp_b % 16];
                rp_b        <= rp_b + 1;
            end else begin
                bad_pop_b <= bad_pop_b + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_word(input int id);
        logic [511:0] w;
        for (int k = 0; k < 8; k++) w[k*64 +: 64] = {id[31:0], 32'(k + 1)};
        return w;
    endfunction

    task automatic push_a(input logic [511:0] w);
        mem_a[wp_a % 64] = w;
        wp_a = wp_a + 1;
        for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), w[k*64 +: 64]});
    endtask

    task automatic push_b(input logic [63:0] w);
        mem_b[wp_b % 16] = w;
        wp_b = wp_b + 1;
    endtask

    // Drains dut against exp_q, optionally with random ready and late pushes.
    task automatic run_stream(input int budget, input bit rnd, input int n_more, input int first_id);
        int          pushed = 0;
        bit          hold = 0;
        bit          fin = 0;
        logic [64:0] prev = '0;
        logic [64:0] e;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            if (pushed < n_more && $urandom_range(0, 9) < 3) begin
                push_a(mk_word(first_id + pushed));
                pushed++;
            end
            m_ready_a = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (hold) chk("hold_stable", {m_valid_a, m_last_a, m_data_a}, {1'b1, prev});
            if (m_valid_a && m_ready_a) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL extra_beat: got %h with no beat outstanding", m_data_a);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_last_a, m_data_a}, e);
                end
            end
            hold = m_valid_a && !m_ready_a;
            prev = {m_last_a, m_data_a};
            fin  = (pushed == n_more) && (exp_q.size() == 0) && !busy_a;
        end
        chk("stream_done", fin, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   b, pops, gap, t, n, first_c;
        bit   hit;
        logic [31:0] idv;

        reset     = 1'b0;
        m_ready_a = 1'b0;
        m_ready_b = 1'b0;

        // Test 1: reset state, then idle with an empty FIFO.
        #12;
        chk("reset_outputs_a", {fifo_re_a, m_valid_a, m_last_a, busy_a, m_data_a}, 0);
        chk("reset_outputs_b", {fifo_re_b, m_valid_b, m_last_b, busy_b, m_data_b}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("idle", {fifo_re_a, m_valid_a, busy_a}, 0);
        end

        // Test 2: single word, per-cycle expectations.
        for (int i = 0; i < 11; i++) begin
            tv[i] = '{push: (i == 0), ready: 1'b1, re: (i == 0), vld: (i >= 2 && i <= 9),
                      dat: (i >= 2 && i <= 9) ? 64'(i - 1) : 64'd0, last: (i == 9),
                      busy: (i >= 1 && i <= 9)};
        end
        exp_q.delete();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (tv[i].push) push_a(mk_word(0));
            m_ready_a = tv[i].ready;
            #1;
            chk($sformatf("single_word[%0d]", i),
                {fifo_re_a, m_valid_a, m_last_a, busy_a, (tv[i].vld ? m_data_a : 64'd0)},
                {tv[i].re, tv[i].vld, tv[i].last, tv[i].busy, tv[i].dat});
        end

        // Test 3: three preloaded words stream without a bubble.
        exp_q.delete();
        b = 0; pops = 0; gap = 0;
        for (int c = 0; c < 60 && b < 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                push_a(mk_word(1)); push_a(mk_word(2)); push_a(mk_word(3));
            end
            #1;
            if (fifo_re_a) pops++;
            if (m_valid_a) begin
                idv = 32'(1 + b / 8);
                chk("b2b_beat", {m_last_a, m_data_a}, {(b % 8 == 7), idv, 32'(b % 8 + 1)});
                b++;
            end else if (b > 0) begin
                gap++;
            end
        end
        @(negedge clk);
        #1;
        if (fifo_re_a) pops++;
        chk("b2b_count", b, 24);
        chk("b2b_gaps", gap, 0);
        chk("b2b_pops", pops, 3);
        chk("b2b_busy_after", busy_a, 0);

        // Test 4: random ready with late pushes.
        exp_q.delete();
        @(negedge clk);
        push_a(mk_word(40)); push_a(mk_word(41)); push_a(mk_word(42));
        run_stream(2000, 1'b1, 5, 43);
        chk("no_pop_on_empty_a", bad_pop_a, 0);

        // Test 5: reset during beat 4 of word 2; remainder of word 2 is dropped.
        exp_q.delete();
        m_ready_a = 1'b1;
        @(negedge clk);
        push_a(mk_word(50)); push_a(mk_word(51)); push_a(mk_word(52));
        t = 0; hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            #1;
            if (m_valid_a) begin
                if (t == 19) begin
                    hit = 1;
                    chk("rst_at_beat", m_data_a, {32'd52, 32'd4});
                end else begin
                    t++;
                end
            end
            if (!hit) @(negedge clk);
        end
        chk("rst_reached", hit, 1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset", {fifo_re_a, m_valid_a, m_last_a, busy_a, m_data_a}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        push_a(mk_word(53));
        #1;
        chk("no_pop_first_cycle", fifo_re_a, 0);
        @(negedge clk);
        #1;
        chk("pop_second_cycle", fifo_re_a, 1);
        push_a(mk_word(54)); push_a(mk_word(55));
        run_stream(400, 1'b0, 0, 0);

        // Test 6: RATIO=1 instance, every beat is last.
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_b(64'hC0DE_0000_0000_0000 | 64'(i));
        repeat (6) @(negedge clk);
        #1;
        chk("r1_prefetch", {fifo_re_b, m_valid_b, busy_b, fifo_empty_b}, {1'b0, 1'b1, 1'b1, 1'b0});
        n = 0; first_c = -1;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            m_ready_b = 1'b1;
            #1;
            if (m_valid_b) begin
                chk("r1_beat", {m_last_b, m_data_b}, {1'b1, 64'hC0DE_0000_0000_0000 | 64'(n)});
                if (n == 0) first_c = c;
                if (n == 1) chk("r1_back_to_back", c - first_c, 1);
                n++;
            end
        end
        chk("r1_count", n, 4);
        @(negedge clk);
        #1;
        chk("r1_idle", busy_b, 0);
        chk("no_pop_on_empty_b", bad_pop_b, 0);
        chk("no_pop_on_empty_a_end", bad_pop_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
